// File: rtl/mips_pkg.sv
// Shared MIPS decode definitions: opcode constants, the per-opcode decode table
// and the ID/EX register layout used by the decode stage.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [4:0] REG_RA   = 5'd31;

    typedef enum logic [1:0] {
        DST_NONE,
        DST_RD,
        DST_RT,
        DST_RA
    } dst_kind_e;

    typedef enum logic [1:0] {
        IMM_SIGN,
        IMM_ZERO,
        IMM_UPPER
    } imm_kind_e;

    typedef struct packed {
        logic      legal;
        logic      wen;
        logic      memrd;
        logic      reads_rt;
        dst_kind_e dst;
        imm_kind_e imm;
    } dec_entry_t;

    typedef struct packed {
        logic        valid;
        logic [5:0]  op;
        logic [5:0]  funct;
        logic [4:0]  dst;
        logic        wen;
        logic        memrd;
        logic [31:0] rs_val;
        logic [31:0] rt_val;
        logic [31:0] imm;
        logic [31:0] pc4;
    } ex_regs_t;

    // reads_rt marks opcodes whose rt field is a source operand (load-use check).
    function automatic dec_entry_t decode_lookup(input logic [5:0] op);
        dec_entry_t e;
        e.legal    = 1'b1;
        e.wen      = 1'b0;
        e.memrd    = 1'b0;
        e.reads_rt = 1'b0;
        e.dst      = DST_NONE;
        e.imm      = IMM_SIGN;
        case (op)
            OP_RTYPE: begin
                e.wen      = 1'b1;
                e.reads_rt = 1'b1;
                e.dst      = DST_RD;
            end
            OP_LW: begin
                e.wen   = 1'b1;
                e.memrd = 1'b1;
                e.dst   = DST_RT;
            end
            OP_ADDI: begin
                e.wen = 1'b1;
                e.dst = DST_RT;
            end
            OP_ANDI, OP_ORI: begin
                e.wen = 1'b1;
                e.dst = DST_RT;
                e.imm = IMM_ZERO;
            end
            OP_LUI: begin
                e.wen = 1'b1;
                e.dst = DST_RT;
                e.imm = IMM_UPPER;
            end
            OP_JAL: begin
                e.wen = 1'b1;
                e.dst = DST_RA;
            end
            OP_SW, OP_BEQ, OP_BNE: begin
                e.reads_rt = 1'b1;
            end
            OP_J: begin
                e.legal = 1'b1;
            end
            default: begin
                e.legal = 1'b0;
            end
        endcase
        return e;
    endfunction

endpackage

// File: rtl/instr_decoder.sv
// Purely combinational MIPS field extraction and control decode for the ID stage.
// Exposes an illegal-opcode flag only when DECODE_ILLEGAL_TRAP_EN is defined.
module instr_decoder
    import mips_pkg::*;
(
    input  logic [31:0] instr,
    output logic [5:0]  op,
    output logic [5:0]  funct,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  dst,
    output logic        wen,
    output logic        memrd,
    output logic        reads_rt,
`ifdef DECODE_ILLEGAL_TRAP_EN
    output logic        illegal,
`endif
    output logic [31:0] imm
);

    dec_entry_t entry;

    always_comb begin
        entry    = decode_lookup(instr[31:26]);
        op       = instr[31:26];
        funct    = instr[5:0];
        rs       = instr[25:21];
        rt       = instr[20:16];
        wen      = entry.wen & entry.legal;
        memrd    = entry.memrd & entry.legal;
        reads_rt = entry.reads_rt;
`ifdef DECODE_ILLEGAL_TRAP_EN
        illegal  = ~entry.legal;
`endif

        case (entry.dst)
            DST_RD:  dst = instr[15:11];
            DST_RT:  dst = instr[20:16];
            DST_RA:  dst = REG_RA;
            default: dst = 5'd0;
        endcase

        case (entry.imm)
            IMM_ZERO:  imm = {16'h0000, instr[15:0]};
            IMM_UPPER: imm = {instr[15:0], 16'h0000};
            default:   imm = {{16{instr[15]}}, instr[15:0]};
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// MIPS decode stage: IF/ID and ID/EX registers, WB bypass, load-use stall, flush.
// Optional ex_illegal output enabled by defining DECODE_ILLEGAL_TRAP_EN.
module decode_stage
(
    input  logic        clock,
    input  logic        reset_0,
    input  logic        if_valid,
    input  logic [31:0] if_instr,
    input  logic [31:0] if_pc4,
    input  logic        ex_stall,
    input  logic        ex_flush,
    input  logic        wb_en,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    output logic [4:0]  rf_addr_a,
    output logic [4:0]  rf_addr_b,
    input  logic [31:0] rf_data_a,
    input  logic [31:0] rf_data_b,
    output logic        if_stall,
    output logic        ex_valid,
    output logic [5:0]  ex_op,
    output logic [5:0]  ex_funct,
    output logic [4:0]  ex_dst,
    output logic        ex_wen,
    output logic        ex_memrd,
    output logic [31:0] ex_rs_val,
    output logic [31:0] ex_rt_val,
    output logic [31:0] ex_imm,
`ifdef DECODE_ILLEGAL_TRAP_EN
    output logic        ex_illegal,
`endif
    output logic [31:0] ex_pc4
);
    import mips_pkg::*;

    logic        ifid_valid_q, ifid_valid_d;
    logic [31:0] ifid_instr_q, ifid_instr_d;
    logic [31:0] ifid_pc4_q, ifid_pc4_d;
    ex_regs_t    ex_q, ex_d;

    logic [5:0]  dec_op, dec_funct;
    logic [4:0]  dec_rs, dec_rt, dec_dst;
    logic        dec_wen, dec_memrd, dec_reads_rt;
    logic [31:0] dec_imm;
    logic        load_use;
`ifdef DECODE_ILLEGAL_TRAP_EN
    logic        dec_illegal;
    logic        ex_illegal_q, ex_illegal_d;
`endif

    instr_decoder u_dec (
        .instr    (ifid_instr_q),
        .op       (dec_op),
        .funct    (dec_funct),
        .rs       (dec_rs),
        .rt       (dec_rt),
        .dst      (dec_dst),
        .wen      (dec_wen),
        .memrd    (dec_memrd),
        .reads_rt (dec_reads_rt),
`ifdef DECODE_ILLEGAL_TRAP_EN
        .illegal  (dec_illegal),
`endif
        .imm      (dec_imm)
    );

    assign rf_addr_a = dec_rs;
    assign rf_addr_b = dec_rt;

    // A result being written back this cycle is not yet visible in the array.
    function automatic logic [31:0] read_operand(
        input logic [4:0]  addr,
        input logic [31:0] rf_data,
        input logic        wen,
        input logic [4:0]  waddr,
        input logic [31:0] wdata
    );
        if (addr == 5'd0)
            return 32'd0;
        else if (wen && (waddr == addr))
            return wdata;
        else
            return rf_data;
    endfunction

    always_comb begin
        load_use = ex_q.valid && ex_q.memrd && (ex_q.dst != 5'd0) && ifid_valid_q &&
                   ((ex_q.dst == dec_rs) || (dec_reads_rt && (ex_q.dst == dec_rt)));
    end

    always_comb begin
        ifid_valid_d = ifid_valid_q;
        ifid_instr_d = ifid_instr_q;
        ifid_pc4_d   = ifid_pc4_q;
        ex_d         = ex_q;
`ifdef DECODE_ILLEGAL_TRAP_EN
        ex_illegal_d = ex_illegal_q;
`endif

        if (ex_flush) begin
            ifid_valid_d = 1'b0;
            ex_d.valid   = 1'b0;
            ex_d.wen     = 1'b0;
            ex_d.memrd   = 1'b0;
`ifdef DECODE_ILLEGAL_TRAP_EN
            ex_illegal_d = 1'b0;
`endif
        end else if (ex_stall) begin
            ex_d = ex_q;
        end else if (load_use) begin
            ex_d.valid   = 1'b0;
            ex_d.wen     = 1'b0;
            ex_d.memrd   = 1'b0;
`ifdef DECODE_ILLEGAL_TRAP_EN
            ex_illegal_d = 1'b0;
`endif
        end else begin
            ex_d.valid   = ifid_valid_q;
            ex_d.op      = dec_op;
            ex_d.funct   = dec_funct;
            ex_d.dst     = dec_dst;
            ex_d.wen     = dec_wen & ifid_valid_q;
            ex_d.memrd   = dec_memrd & ifid_valid_q;
            ex_d.rs_val  = read_operand(dec_rs, rf_data_a, wb_en, wb_addr, wb_data);
            ex_d.rt_val  = read_operand(dec_rt, rf_data_b, wb_en, wb_addr, wb_data);
            ex_d.imm     = dec_imm;
            ex_d.pc4     = ifid_pc4_q;
`ifdef DECODE_ILLEGAL_TRAP_EN
            ex_illegal_d = dec_illegal & ifid_valid_q;
`endif
            ifid_valid_d = if_valid;
            ifid_instr_d = if_instr;
            ifid_pc4_d   = if_pc4;
        end
    end

    always_ff @(posedge clock or negedge reset_0) begin
        if (!reset_0) begin
            ifid_valid_q <= 1'b0;
            ifid_instr_q <= 32'd0;
            ifid_pc4_q   <= 32'd0;
            ex_q         <= '0;
`ifdef DECODE_ILLEGAL_TRAP_EN
            ex_illegal_q <= 1'b0;
`endif
        end else begin
            ifid_valid_q <= ifid_valid_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_pc4_q   <= ifid_pc4_d;
            ex_q         <= ex_d;
`ifdef DECODE_ILLEGAL_TRAP_EN
            ex_illegal_q <= ex_illegal_d;
`endif
        end
    end

    // Flush wins over stall, and nothing is held while in reset.
    assign if_stall  = reset_0 && !ex_flush && (ex_stall || load_use);

    assign ex_valid  = ex_q.valid;
    assign ex_op     = ex_q.op;
    assign ex_funct  = ex_q.funct;
    assign ex_dst    = ex_q.dst;
    assign ex_wen    = ex_q.wen;
    assign ex_memrd  = ex_q.memrd;
    assign ex_rs_val = ex_q.rs_val;
    assign ex_rt_val = ex_q.rt_val;
    assign ex_imm    = ex_q.imm;
    assign ex_pc4    = ex_q.pc4;
`ifdef DECODE_ILLEGAL_TRAP_EN
    assign ex_illegal = ex_illegal_q;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: a cycle model predicts issued instructions
// into a queue, and an independent monitor pops and compares each issue.
module tb_decode_stage;

    logic        clock = 1'b0;
    logic        reset_0;
    logic        if_valid;
    logic [31:0] if_instr, if_pc4;
    logic        ex_stall, ex_flush;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic [4:0]  rf_addr_a, rf_addr_b;
    logic [31:0] rf_data_a, rf_data_b;
    logic        if_stall, ex_valid, ex_wen, ex_memrd;
    logic [5:0]  ex_op, ex_funct;
    logic [4:0]  ex_dst;
    logic [31:0] ex_rs_val, ex_rt_val, ex_imm, ex_pc4;
`ifdef DECODE_ILLEGAL_TRAP_EN
    logic        ex_illegal;
`endif

    always #5 clock = ~clock;

    logic [31:0] regs [32];
    assign rf_data_a = regs[rf_addr_a];
    assign rf_data_b = regs[rf_addr_b];

    decode_stage dut (
        .clock      (clock),
        .reset_0    (reset_0),
        .if_valid   (if_valid),
        .if_instr   (if_instr),
        .if_pc4     (if_pc4),
        .ex_stall   (ex_stall),
        .ex_flush   (ex_flush),
        .wb_en      (wb_en),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .rf_addr_a  (rf_addr_a),
        .rf_addr_b  (rf_addr_b),
        .rf_data_a  (rf_data_a),
        .rf_data_b  (rf_data_b),
        .if_stall   (if_stall),
        .ex_valid   (ex_valid),
        .ex_op      (ex_op),
        .ex_funct   (ex_funct),
        .ex_dst     (ex_dst),
        .ex_wen     (ex_wen),
        .ex_memrd   (ex_memrd),
        .ex_rs_val  (ex_rs_val),
        .ex_rt_val  (ex_rt_val),
        .ex_imm     (ex_imm),
`ifdef DECODE_ILLEGAL_TRAP_EN
        .ex_illegal (ex_illegal),
`endif
        .ex_pc4     (ex_pc4)
    );

    typedef struct {
        logic [5:0]  op;
        logic [5:0]  funct;
        logic [4:0]  dst;
        logic        wen;
        logic        memrd;
        logic        illegal;
        logic [31:0] rs_val;
        logic [31:0] rt_val;
        logic [31:0] imm;
        logic [31:0] pc4;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int failures = 0;

    // Reference state: what sits in IF/ID, and what the model last issued to EX.
    logic        m_ifid_valid = 1'b0;
    logic [31:0] m_ifid_instr = 32'd0;
    logic [31:0] m_ifid_pc4 = 32'd0;
    logic        m_ex_valid = 1'b0;
    logic        m_ex_memrd = 1'b0;
    logic [4:0]  m_ex_dst = 5'd0;

    localparam logic [31:0] NOP = 32'h0000_0000;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    function automatic logic [31:0] opnd(input logic [4:0] a, input logic wbe, input logic [4:0] wba, input logic [31:0] wbd);
        if (a == 5'd0) return 32'd0;
        if (wbe && wba == a) return wbd;
        return regs[a];
    endfunction

    function automatic exp_t model(input logic [31:0] instr, input logic [31:0] pc4,
                                   input logic wbe, input logic [4:0] wba, input logic [31:0] wbd);
        exp_t e;
        logic [5:0]  op;
        logic [15:0] imm16;
        op = instr[31:26];
        imm16 = instr[15:0];
        e.op = op;
        e.funct = instr[5:0];
        e.pc4 = pc4;
        e.wen = 1'b0;
        e.memrd = 1'b0;
        e.dst = 5'd0;
        e.illegal = 1'b0;
        case (op)
            6'h00:                      begin e.wen = 1'b1; e.dst = instr[15:11]; end
            6'h23:                      begin e.wen = 1'b1; e.memrd = 1'b1; e.dst = instr[20:16]; end
            6'h08, 6'h0C, 6'h0D, 6'h0F: begin e.wen = 1'b1; e.dst = instr[20:16]; end
            6'h03:                      begin e.wen = 1'b1; e.dst = 5'd31; end
            6'h2B, 6'h04, 6'h05, 6'h02: e.wen = 1'b0;
            default:                    e.illegal = 1'b1;
        endcase
        if (op == 6'h0C || op == 6'h0D) e.imm = {16'h0, imm16};
        else if (op == 6'h0F)           e.imm = {imm16, 16'h0};
        else                            e.imm = {{16{imm16[15]}}, imm16};
        e.rs_val = opnd(instr[25:21], wbe, wba, wbd);
        e.rt_val = opnd(instr[20:16], wbe, wba, wbd);
        return e;
    endfunction

    function automatic bit reads_reg(input logic [31:0] instr, input logic [4:0] r);
        logic [5:0] op;
        op = instr[31:26];
        if (r == instr[25:21]) return 1'b1;
        if ((op == 6'h00 || op == 6'h2B || op == 6'h04 || op == 6'h05) && r == instr[20:16]) return 1'b1;
        return 1'b0;
    endfunction

    // One clock of stimulus: drive at negedge, check if_stall, then advance the model at the edge.
    task automatic applyStimulus(input logic v, input logic [31:0] instr, input logic [31:0] pc4,
                                 input logic stall, input logic flush,
                                 input logic wbe, input logic [4:0] wba, input logic [31:0] wbd);
        bit   hz;
        exp_t e;
        @(negedge clock);
        if_valid = v;
        if_instr = instr;
        if_pc4   = pc4;
        ex_stall = stall;
        ex_flush = flush;
        wb_en    = wbe;
        wb_addr  = wba;
        wb_data  = wbd;
        hz = m_ex_valid && m_ex_memrd && (m_ex_dst != 5'd0) && m_ifid_valid && reads_reg(m_ifid_instr, m_ex_dst);
        #1;
        checkOutput("if_stall", {31'd0, if_stall}, {31'd0, (!flush && (stall || hz))});
        @(posedge clock);
        if (flush) begin
            m_ifid_valid = 1'b0;
            m_ex_valid   = 1'b0;
        end else if (stall) begin
            m_ex_valid = m_ex_valid;
        end else if (hz) begin
            m_ex_valid = 1'b0;
        end else begin
            if (m_ifid_valid) begin
                e = model(m_ifid_instr, m_ifid_pc4, wbe, wba, wbd);
                sb.push_back(e);
                m_ex_valid = 1'b1;
                m_ex_memrd = e.memrd;
                m_ex_dst   = e.dst;
            end else begin
                m_ex_valid = 1'b0;
            end
            m_ifid_valid = v;
            m_ifid_instr = instr;
            m_ifid_pc4   = pc4;
        end
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_ex_valid"}, {31'd0, ex_valid}, 32'd0);
        checkOutput({tag, "_ex_wen"}, {31'd0, ex_wen}, 32'd0);
        checkOutput({tag, "_ex_memrd"}, {31'd0, ex_memrd}, 32'd0);
        checkOutput({tag, "_ex_dst"}, {27'd0, ex_dst}, 32'd0);
        checkOutput({tag, "_ex_op"}, {26'd0, ex_op}, 32'd0);
        checkOutput({tag, "_ex_rs_val"}, ex_rs_val, 32'd0);
        checkOutput({tag, "_ex_imm"}, ex_imm, 32'd0);
        checkOutput({tag, "_ex_pc4"}, ex_pc4, 32'd0);
        checkOutput({tag, "_if_stall"}, {31'd0, if_stall}, 32'd0);
`ifdef DECODE_ILLEGAL_TRAP_EN
        checkOutput({tag, "_ex_illegal"}, {31'd0, ex_illegal}, 32'd0);
`endif
    endtask

    task automatic model_reset();
        m_ifid_valid = 1'b0;
        m_ex_valid   = 1'b0;
        m_ex_memrd   = 1'b0;
        m_ex_dst     = 5'd0;
        sb.delete();
    endtask

    function automatic logic [31:0] rand_instr();
        logic [5:0] ops [12];
        logic [5:0] op;
        int idx;
        ops = '{6'h00, 6'h23, 6'h23, 6'h08, 6'h0C, 6'h0D, 6'h0F, 6'h03, 6'h2B, 6'h04, 6'h05, 6'h02};
        idx = $urandom_range(0, 13);
        if (idx >= 12) op = (idx == 12) ? 6'h3F : 6'($urandom);
        else           op = ops[idx];
        return {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom)};
    endfunction

    // Monitor: every fresh ID/EX load is compared with the next predicted issue.
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (reset_0 === 1'b1) begin
                if (ex_flush) checkOutput("flush_ex_valid", {31'd0, ex_valid}, 32'd0);
                if (!ex_stall) begin
                    if (ex_valid && sb.size() == 0) begin
                        checkOutput("spurious_issue", {31'd0, ex_valid}, 32'd0);
                    end else if (ex_valid) begin
                        e = sb.pop_front();
                        checkOutput("ex_op", {26'd0, ex_op}, {26'd0, e.op});
                        checkOutput("ex_funct", {26'd0, ex_funct}, {26'd0, e.funct});
                        checkOutput("ex_wen", {31'd0, ex_wen}, {31'd0, e.wen});
                        checkOutput("ex_memrd", {31'd0, ex_memrd}, {31'd0, e.memrd});
                        if (e.wen) checkOutput("ex_dst", {27'd0, ex_dst}, {27'd0, e.dst});
                        checkOutput("ex_rs_val", ex_rs_val, e.rs_val);
                        checkOutput("ex_rt_val", ex_rt_val, e.rt_val);
                        checkOutput("ex_imm", ex_imm, e.imm);
                        checkOutput("ex_pc4", ex_pc4, e.pc4);
`ifdef DECODE_ILLEGAL_TRAP_EN
                        checkOutput("ex_illegal", {31'd0, ex_illegal}, {31'd0, e.illegal});
`endif
                    end else begin
                        checkOutput("bubble_wen", {31'd0, ex_wen}, 32'd0);
                        checkOutput("bubble_memrd", {31'd0, ex_memrd}, 32'd0);
                    end
                end
            end
        end
    end

    initial begin
        logic [31:0] lw3, add_dep, addi5, addi_r8, addi_r0;
        lw3     = {6'h23, 5'd1, 5'd3, 16'd4};
        add_dep = {6'h00, 5'd3, 5'd2, 5'd4, 5'd0, 6'h20};
        addi5   = {6'h08, 5'd0, 5'd5, 16'd7};
        addi_r8 = {6'h08, 5'd8, 5'd9, 16'd1};
        addi_r0 = {6'h08, 5'd0, 5'd9, 16'd1};

        for (int i = 0; i < 32; i++) regs[i] = $urandom;
        regs[0] = 32'hFFFF_FFFF;

        reset_0  = 1'b0;
        if_valid = 1'b0;
        if_instr = 32'd0;
        if_pc4   = 32'd0;
        ex_stall = 1'b1;
        ex_flush = 1'b0;
        wb_en    = 1'b0;
        wb_addr  = 5'd0;
        wb_data  = 32'd0;
        #1;
        checkReset("reset");
        @(negedge clock);
        @(negedge clock);
        reset_0  = 1'b1;
        ex_stall = 1'b0;

        // addi $5,$0,7 then NOPs
        applyStimulus(1, addi5, 32'h100, 0, 0, 0, 0, 0);
        applyStimulus(1, NOP, 32'h104, 0, 0, 0, 0, 0);
        applyStimulus(1, NOP, 32'h108, 0, 0, 0, 0, 0);

        // lw $3 then dependent add; add issues with $3 from the bypass
        applyStimulus(1, lw3, 32'h200, 0, 0, 0, 0, 0);
        applyStimulus(1, add_dep, 32'h204, 0, 0, 0, 0, 0);
        applyStimulus(1, NOP, 32'h208, 0, 0, 0, 0, 0);
        applyStimulus(1, NOP, 32'h208, 0, 0, 1, 5'd3, 32'h1234_5678);
        applyStimulus(1, NOP, 32'h20C, 0, 0, 0, 0, 0);

        // WB bypass of $8, then a write to $0 that must be ignored
        applyStimulus(1, addi_r8, 32'h300, 0, 0, 0, 0, 0);
        applyStimulus(1, addi_r0, 32'h304, 0, 0, 1, 5'd8, 32'hDEAD_BEEF);
        applyStimulus(1, NOP, 32'h308, 0, 0, 1, 5'd0, 32'hDEAD_BEEF);
        applyStimulus(1, NOP, 32'h30C, 0, 0, 0, 0, 0);

        // Flush with simultaneous stall and pending load-use hazard
        applyStimulus(1, lw3, 32'h400, 0, 0, 0, 0, 0);
        applyStimulus(1, add_dep, 32'h404, 0, 0, 0, 0, 0);
        applyStimulus(1, NOP, 32'h408, 1, 1, 0, 0, 0);
        applyStimulus(0, NOP, 32'h40C, 0, 0, 0, 0, 0);
        applyStimulus(0, NOP, 32'h410, 0, 0, 0, 0, 0);

        // Unlisted opcode 0x3F
        applyStimulus(1, {6'h3F, 5'd1, 5'd2, 16'h8001}, 32'h500, 0, 0, 0, 0, 0);
        applyStimulus(1, NOP, 32'h504, 0, 0, 0, 0, 0);
        applyStimulus(0, NOP, 32'h508, 0, 0, 0, 0, 0);

        // Asynchronous reset in the middle of a load-use stall
        applyStimulus(1, lw3, 32'h600, 0, 0, 0, 0, 0);
        applyStimulus(1, add_dep, 32'h604, 0, 0, 0, 0, 0);
        #3;
        ex_stall = 1'b1;
        #1;
        checkOutput("stall_before_reset", {31'd0, if_stall}, 32'd1);
        reset_0 = 1'b0;
        #1;
        checkReset("async_reset");
        model_reset();
        @(negedge clock);
        @(negedge clock);
        reset_0  = 1'b1;
        ex_stall = 1'b0;
        if_valid = 1'b0;
        applyStimulus(0, NOP, 32'h700, 0, 0, 0, 0, 0);
        applyStimulus(0, NOP, 32'h704, 0, 0, 0, 0, 0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            applyStimulus(1'($urandom_range(0, 4) != 0), rand_instr(), $urandom & 32'hFFFF_FFFC,
                          1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 14) == 0),
                          1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
        end

        for (int i = 0; i < 4; i++) applyStimulus(0, NOP, 32'd0, 0, 0, 0, 0, 0);
        #2;
        checkOutput("scoreboard_drained", sb.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameters: none; all datapaths are fixed at 32 bits and register addresses at 5 bits.
REQ-002 Clocking: one clock; reset is asynchronous and active-low (clock, reset_0).
REQ-003 clock  in  1  rising-edge clock for all state.
REQ-004 reset_0  in  1  asynchronous active-low reset.
REQ-005 if_valid  in  1  fetch presents a valid instruction this cycle.
REQ-006 if_instr  in  32  fetched MIPS instruction.
REQ-007 if_pc4  in  32  PC+4 of the fetched instruction.
REQ-008 ex_stall  in  1  downstream cannot accept; hold all state.
REQ-009 ex_flush  in  1  branch/jump redirect from EX; kill younger instructions.
REQ-010 wb_en, wb_addr, wb_data  in  1/5/32  write-back port, also driven into the register array.
REQ-011 rf_addr_a, rf_addr_b  out  5/5  rs/rt of the IF/ID instruction, to the register array.
REQ-012 rf_data_a, rf_data_b  in  32/32  combinational read data from the register array.
REQ-013 if_stall  out  1  fetch must hold its PC and instruction.
REQ-014 ex_valid  out  1  ID/EX slot holds a real instruction.
REQ-015 ex_op, ex_funct, ex_dst  out  6/6/5  opcode, funct, destination register.
REQ-016 ex_wen, ex_memrd  out  1/1  writes a register; is a load.
REQ-017 ex_rs_val, ex_rt_val, ex_imm, ex_pc4  out  32 each  operands, extended immediate, PC+4.

Function
REQ-018 Two register stages SHALL exist: IF/ID (valid, instr, pc4) and ID/EX (all ex_* outputs); ID/EX outputs are valid one edge after the instruction enters IF/ID.
REQ-019 rf_addr_a/rf_addr_b SHALL be IF/ID instr[25:21]/[20:16], combinational.
REQ-020 WB bypass: if wb_en, wb_addr equals the read address, and wb_addr != 0, the latched operand SHALL be wb_data; otherwise it SHALL be rf_data; register 0 SHALL always read 0.
REQ-021 Decode: op 0x00 → wen=1, dst=rd; 0x23 lw → wen=1, memrd=1, dst=rt; 0x08/0x0C/0x0D/0x0F → wen=1, dst=rt; 0x03 jal → wen=1, dst=31; 0x2B, 0x04, 0x05, 0x02 → wen=0; any other op → wen=0, memrd=0.
REQ-022 Immediate: sign-extended for all ops except 0x0C/0x0D (zero-extended) and 0x0F (imm<<16).
REQ-023 Load-use hazard: ex_valid && ex_memrd && ex_dst != 0 && ex_dst matches a source register read by the IF/ID instruction (rs always; rt for op 0x00/0x2B/0x04/0x05) SHALL assert if_stall, hold IF/ID, and load a bubble (ex_valid=0) into ID/EX; the stall lasts exactly one cycle.
REQ-024 Priority per edge: ex_flush > ex_stall > load-use > normal advance.
REQ-025 ex_flush SHALL clear the IF/ID and ID/EX valid bits at the next edge, even when ex_stall or a hazard is also active.
REQ-026 ex_stall SHALL hold both stages unchanged and assert if_stall.
REQ-027 Bubbles (ex_valid=0) SHALL also force ex_wen=0 and ex_memrd=0.

Reset
REQ-028 While reset_0=0, all valid bits and all ex_* registers SHALL be 0 and if_stall SHALL be 0; reset mid-stall SHALL discard the held instruction.

Configuration
REQ-029 With DECODE_ILLEGAL_TRAP_EN defined, an extra output ex_illegal (1 bit, reset 0) SHALL be set with ex_valid for an unlisted opcode; without the macro, the port is absent and unlisted opcodes pass as NOPs.

Structure
REQ-030 Opcode constants and the dst/wen/imm-kind decode table SHALL live in the shared package mips_pkg.
REQ-031 Combinational decode SHALL be a single sub-module, instr_decoder; the pipeline registers and hazard logic stay in decode_stage.

Verification
REQ-032 Test 1: addi $5,$0,7 followed by a NOP → ex_valid=1, ex_dst=5, ex_wen=1, ex_imm=7 one edge after IF/ID load.
REQ-033 Test 2: lw $3 then add $4,$3,$2 → if_stall=1 for one cycle and a single bubble; add then issues with ex_rs_val taken from the bypass when wb_addr=3.
REQ-034 Test 3: wb_en=1, wb_addr=8, wb_data=0xDEADBEEF in the same cycle that $8 is decoded → ex_rs_val=0xDEADBEEF; with wb_addr=0 the result is 0.
REQ-035 Test 4: ex_flush together with ex_stall and a pending load-use hazard → both valids are 0 next cycle.
REQ-036 Test 5: assert reset_0 low mid-stall → outputs are 0 asynchronously; op 0x3F gives ex_wen=0, and ex_illegal=1 only under DECODE_ILLEGAL_TRAP_EN.
